johnson_phase_arbiter: RTL
==========================

# johnson_phase_arbiter

Shares a single Johnson phase generator between `NUM_REQ` requesters. It round-robin arbitrates, grants one requester at a time, and runs the shared Johnson counter for a requested number of full periods. It then reports completion and re-arbitrates. It sits between client blocks needing multi-phase timing strobes and the Johnson counter datapath, and replaces ad-hoc start/stop command driving.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `COUNT_WIDTH`, 8: Johnson counter width. Period = `2*COUNT_WIDTH` states.
- `LEN_W`, 4: width of per-requester burst length.

Ports:
- `Clk_In` in 1: single clock. All logic on rising edge.
- `Reset_In` in 1: reset is synchronous and active-high.
- `Enable_In` in 1: 0 freezes the block; all registers hold.
- `Req_In` in `NUM_REQ`: level requests, held until `Done_Out`.
- `Burst_Len_In` in `NUM_REQ*LEN_W`: requester i length at bits [i*LEN_W +: LEN_W]. Value is full periods; 0 is treated as 1.
- `Grant_Out` out `NUM_REQ`: one-hot grant, high throughout RUN.
- `Busy_Out` out 1: high in RUN.
- `Phase_Valid_Out` out 1: high in RUN; `Phase_Out` is meaningful.
- `Phase_Out` out `COUNT_WIDTH`: current Johnson state.
- `Done_Out` out 1: one-cycle completion pulse.
- `Abort_Out` out 1: qualifies `Done_Out`. 1 means the burst ended early.
- `Done_Id_Out` out `$clog2(NUM_REQ)`: index of the finishing requester, valid with `Done_Out`.

## Operation
States: IDLE, RUN, DONE.
- **IDLE, any `Req_In` bit set:**
  - Select the first set bit searching upward from `rr_ptr`, wrapping.
  - Register `Grant_Out`, `grant_id`, and `remaining` = max(len,1).
  - Load the counter with 0 and go to RUN.
- **RUN, each cycle:**
  - Counter advances to {c[W-2:0], ~c[W-1]}.
  - Sequence for W=8: 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80, then 00.
  - On the advance from 8'h80 to 00, `remaining` decrements.
  - When c==last state (MSB=1, others 0) and `remaining`==1, go to DONE with Abort=0.
- **RUN, granted `Req_In` bit drops:** go to DONE next edge with Abort=1. The counter holds its value.
- **DONE (one cycle):**
  - `Done_Out`=1 and `Done_Id_Out`=`grant_id`; `Grant_Out`=0.
  - `rr_ptr` advances to (`grant_id`+1) mod `NUM_REQ`.
  - Go to IDLE.
- **Requests in other states:** ignored outside IDLE; no queueing beyond the level `Req_In`.
- **`Enable_In`=0:** state, counter, `remaining`, and `rr_ptr` hold. Outputs keep their values, so a `Done_Out` pulse is stretched until `Enable_In`=1.
- **Reset mid-burst:** immediate return to IDLE. No `Done_Out` is produced.
- **Reset values:**
  - State IDLE, `rr_ptr`=0, counter=0.
  - `Grant_Out`, `Busy_Out`, `Phase_Valid_Out`, `Done_Out`, `Abort_Out`, `Done_Id_Out`, and `Phase_Out` all 0.

## Timing
- **Grant latency:** `Req_In` sampled high in IDLE at edge k gives `Grant_Out`/`Busy_Out` high from k+1, with `Phase_Out`=0 in the first RUN cycle.
- **Normal burst:** RUN lasts exactly `2*COUNT_WIDTH*len` cycles when `Enable_In` stays 1. `Done_Out` is in the following cycle.
- **Minimum request-to-request turnaround:** DONE (1) + IDLE (1). The next grant appears 2 cycles after RUN ends.
- **Abort:** `Req_In` low at edge k during RUN gives DONE at k+1 with `Abort_Out`=1.
- **Outputs:** all registered except `Phase_Out`, which is the counter register directly. There are no combinational input-to-output paths.

## Structure
- **Package `johnson_arb_pkg`:**
  - State enum (IDLE/RUN/DONE).
  - `PERIOD` = 2*`COUNT_WIDTH`.
  - A function returning the terminal Johnson state.
  - A round-robin priority-select function.
- **Sub-module `johnson_phase_gen`:** W-bit Johnson register with synchronous `load_zero` and `advance` inputs, plus a `wrap` flag (c==terminal). The arbiter FSM instantiates one.

## Test plan
- **Single request, len=1:** Req_In=0001, Burst_Len=1. Grant=0001 one cycle later, 16 RUN cycles with Phase_Out 00→80 in the listed sequence, Done_Out=1, Done_Id=0, Abort=0.
- **len=0 and len=3:** len=0 gives 16 RUN cycles. len=3 gives 48 RUN cycles, and Phase_Out returns to 00 exactly twice before Done.
- **Round-robin fairness:** Req_In=1111, all len=1. Grants in order 0,1,2,3,0, each separated by 16 RUN + 2 cycles.
- **Abort:** Req_In[2] drops at RUN cycle 5 (Phase_Out=1F). Done_Out with Abort=1 and Done_Id=2 next cycle. rr_ptr moves to 3.
- **Enable pause:** Enable_In=0 for 4 cycles at Phase_Out=0F. Phase_Out holds 0F and RUN length becomes 20 cycles.
- **Reset mid-burst:** Reset_In at Phase_Out=FE. Next cycle all outputs 0 and state IDLE, no Done_Out. A request held high re-grants to index 0.

Source files
------------

// File: rtl/johnson_phase_arbiter_pkg.sv
// Shared types and helpers for the Johnson phase arbiter.
//   arb_state_t    : arbiter FSM states
//   rr_sel_t       : result of the round-robin search (found flag + index)
//   johnson_period : number of states in one Johnson period for a width
//   johnson_last   : terminal Johnson state (MSB set, all other bits clear)
//   rr_select      : first set request at or above ptr, wrapping at n
package johnson_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } arb_state_t;

  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_sel_t;

  function automatic int unsigned johnson_period(int unsigned w);
    return 2 * w;
  endfunction

  // Returned wide; callers truncate to their counter width.
  function automatic logic [63:0] johnson_last(int unsigned w);
    return 64'(1) << (w - 1);
  endfunction

  function automatic rr_sel_t rr_select(logic [MAX_REQ-1:0] req,
                                        logic [2:0]         ptr,
                                        int unsigned        n);
    rr_sel_t    s;
    logic [2:0] k;
    s = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = 3'((32'(ptr) + i) % n);
      if (i < n && !s.found && req[k]) begin
        s.found = 1'b1;
        s.idx   = k;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/johnson_phase_arbiter_if.sv
// Request/grant/phase bundle between client blocks and the arbiter.
//   master : client side (drives Enable_In, Req_In, Burst_Len_In)
//   slave  : arbiter side (drives Grant_Out, Busy_Out, Phase_Valid_Out,
//            Phase_Out, Done_Out, Abort_Out, Done_Id_Out)
interface johnson_phase_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned LEN_W       = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic                     Enable_In;
  logic [NUM_REQ-1:0]       Req_In;
  logic [NUM_REQ*LEN_W-1:0] Burst_Len_In;
  logic [NUM_REQ-1:0]       Grant_Out;
  logic                     Busy_Out;
  logic                     Phase_Valid_Out;
  logic [COUNT_WIDTH-1:0]   Phase_Out;
  logic                     Done_Out;
  logic                     Abort_Out;
  logic [ID_W-1:0]          Done_Id_Out;

  modport master (
    output Enable_In, Req_In, Burst_Len_In,
    input  Grant_Out, Busy_Out, Phase_Valid_Out, Phase_Out,
           Done_Out, Abort_Out, Done_Id_Out
  );

  modport slave (
    input  Enable_In, Req_In, Burst_Len_In,
    output Grant_Out, Busy_Out, Phase_Valid_Out, Phase_Out,
           Done_Out, Abort_Out, Done_Id_Out
  );
endinterface

// File: rtl/johnson_phase_gen.sv
// W-bit Johnson counter shared by all requesters.
//   Clk_In, Reset_In : clock, synchronous active-high reset (count -> 0)
//   load_zero        : clear count (priority over advance)
//   advance          : step to {c[W-2:0], ~c[W-1]}
//   count            : current Johnson state
//   wrap             : count is the terminal state of the period
module johnson_phase_gen import johnson_arb_pkg::*; #(
  parameter int unsigned W = 8
) (
  input  logic         Clk_In,
  input  logic         Reset_In,
  input  logic         load_zero,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(johnson_last(W));

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (advance) begin
      count <= {count[W-2:0], ~count[W-1]};
    end
  end

  assign wrap = (count == LAST);
endmodule

// File: rtl/johnson_phase_arbiter.sv
// Round-robin arbiter sharing one Johnson phase generator between NUM_REQ
// requesters. A granted requester gets max(len,1) full Johnson periods,
// then a one-cycle Done pulse (Abort set if its request dropped early).
//   Clk_In   : clock, rising edge
//   Reset_In : synchronous active-high reset
//   bus      : slave side of johnson_phase_arbiter_if (enable, requests,
//              burst lengths in; grant, busy, phase, done/abort/id out)
module johnson_phase_arbiter import johnson_arb_pkg::*; #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned LEN_W       = 4
) (
  input logic                   Clk_In,
  input logic                   Reset_In,
  johnson_phase_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    done_id_q;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   sel_len;
  logic               busy_q;
  logic               done_q;
  logic               abort_q;
  logic               load_zero;
  logic               advance;
  logic               wrap;
  logic               granted_req;
  logic               last_period;
  logic               finish;
  rr_sel_t            sel;
  logic [COUNT_WIDTH-1:0] phase;

  assign sel         = rr_select(MAX_REQ'(bus.Req_In), 3'(rr_ptr), NUM_REQ);
  assign granted_req = |(bus.Req_In & grant_q);
  assign last_period = (remaining == LEN_W'(1));
  assign finish      = !granted_req || (wrap && last_period);

  always_comb begin
    sel_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == sel.idx) sel_len = bus.Burst_Len_In[i*LEN_W +: LEN_W];
    end
  end

  // Counter control is gated by the same conditions as the FSM so the
  // counter freezes on abort, on the final state, and while disabled.
  assign load_zero = bus.Enable_In && (state == ST_IDLE) && sel.found;
  assign advance   = bus.Enable_In && (state == ST_RUN) && !finish;

  johnson_phase_gen #(.W(COUNT_WIDTH)) u_gen (
    .Clk_In    (Clk_In),
    .Reset_In  (Reset_In),
    .load_zero (load_zero),
    .advance   (advance),
    .count     (phase),
    .wrap      (wrap)
  );

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      done_id_q <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else if (bus.Enable_In) begin
      unique case (state)
        ST_IDLE: begin
          if (sel.found) begin
            grant_q   <= NUM_REQ'(1) << sel.idx;
            grant_id  <= ID_W'(sel.idx);
            remaining <= (sel_len == '0) ? LEN_W'(1) : sel_len;
            busy_q    <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (finish) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            abort_q   <= !granted_req;
            done_id_q <= grant_id;
            state     <= ST_DONE;
          end else if (wrap) begin
            remaining <= remaining - 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          abort_q <= 1'b0;
          rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Grant_Out       = grant_q;
  assign bus.Busy_Out        = busy_q;
  assign bus.Phase_Valid_Out = busy_q;
  assign bus.Phase_Out       = phase;
  assign bus.Done_Out        = done_q;
  assign bus.Abort_Out       = abort_q;
  assign bus.Done_Id_Out     = done_id_q;
endmodule
